// File: rtl/zero_count_pkg.sv
// Shared types and helpers for the streaming zero-count accumulator.
package zero_count_pkg;

  // Frame FSM: IDLE waits for a first beat, ACC sums beats, DONE holds the result.
  typedef enum logic [1:0] {
    ZC_IDLE = 2'd0,
    ZC_ACC  = 2'd1,
    ZC_DONE = 2'd2
  } zc_state_t;

  // Width needed to hold a per-beat zero count in the range 0..2*len.
  function automatic int zc_cnt_w(int len);
    return $clog2(2 * len + 1);
  endfunction

endpackage

// File: rtl/zero_popcount.sv
// Combinational per-beat zero count of an operand pair.
module zero_popcount
  import zero_count_pkg::*;
#(
  parameter int LEN = 4
) (
  input  logic [LEN-1:0]           i_a,
  input  logic [LEN-1:0]           i_b,
  output logic [zc_cnt_w(LEN)-1:0] o_cz
);

  localparam int CNT_W = zc_cnt_w(LEN);

  // Zero bits of each operand are the set bits of its complement; the sum never exceeds 2*LEN.
  always_comb begin
    o_cz = CNT_W'($countones(~i_a)) + CNT_W'($countones(~i_b));
  end

endmodule

// File: rtl/zero_count_accum.sv
// Streaming zero-count accumulator: sums zero bits of i_a/i_b over a frame ended
// by i_last and presents the frame total, beat count and overflow flag.
// Build option ZERO_CNT_SAT_EN: when defined the accumulator saturates at its
// maximum instead of wrapping.
//
// Handshakes: a beat transfers on a rising edge where i_valid && o_ready; a
// result transfers on a rising edge where o_valid && i_ready. o_valid and the
// result fields stay stable until the result transfers. o_ready is low while
// a result is pending and during reset, so a result and a beat never transfer
// in the same cycle.
module zero_count_accum
  import zero_count_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int OUT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [LEN-1:0]   i_a,
  input  logic [LEN-1:0]   i_b,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_zeros,
  output logic             o_carry,
  output logic [OUT_W-1:0] o_beats,
  output zc_state_t        o_state
);

  localparam int CNT_W = zc_cnt_w(LEN);

  zc_state_t         state;
  logic [CNT_W-1:0]  cz;
  logic [OUT_W-1:0]  cz_ext;
  logic [OUT_W:0]    sum;
  logic [OUT_W-1:0]  add_acc;
  logic              add_ovf;

  zero_popcount #(
    .LEN (LEN)
  ) u_popcount (
    .i_a  (i_a),
    .i_b  (i_b),
    .o_cz (cz)
  );

  assign o_state = state;

  // Beats are accepted in IDLE and ACC, never while a result waits or in reset.
  always_comb begin
    o_ready = !i_rst && (state != ZC_DONE);
  end

  // Accumulator add with one extra bit to catch the carry-out.
  always_comb begin
    cz_ext  = OUT_W'(cz);
    sum     = {1'b0, o_zeros} + {1'b0, cz_ext};
    add_ovf = sum[OUT_W];
`ifdef ZERO_CNT_SAT_EN
    add_acc = add_ovf ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
`else
    add_acc = sum[OUT_W-1:0];
`endif
  end

  // Frame FSM with the accumulator, beat counter and sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ZC_IDLE;
      o_zeros <= '0;
      o_beats <= '0;
      o_carry <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        ZC_IDLE: begin
          if (i_valid) begin
            o_zeros <= cz_ext;
            o_beats <= OUT_W'(1);
            o_carry <= 1'b0;
            if (i_last) begin
              state   <= ZC_DONE;
              o_valid <= 1'b1;
            end else begin
              state <= ZC_ACC;
            end
          end
        end
        ZC_ACC: begin
          if (i_valid) begin
            o_zeros <= add_acc;
            o_beats <= o_beats + OUT_W'(1);
            o_carry <= o_carry | add_ovf;
            if (i_last) begin
              state   <= ZC_DONE;
              o_valid <= 1'b1;
            end
          end
        end
        ZC_DONE: begin
          if (i_ready) begin
            state   <= ZC_IDLE;
            o_valid <= 1'b0;
            o_carry <= 1'b0;
          end
        end
        default: begin
          state   <= ZC_IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zero_count_accum.sv
// Bench for zero_count_accum (LEN=4, OUT_W=4): directed frames plus random
// frames with gaps and random backpressure, checked by a result scoreboard.
module tb_zero_count_accum;
  import zero_count_pkg::*;

  localparam int LEN   = 4;
  localparam int OUT_W = 4;
  localparam int W     = 2 * OUT_W + 1;

  logic             i_clk;
  logic             i_rst;
  logic             i_valid;
  logic             o_ready;
  logic [LEN-1:0]   i_a;
  logic [LEN-1:0]   i_b;
  logic             i_last;
  logic             o_valid;
  logic             i_ready;
  logic [OUT_W-1:0] o_zeros;
  logic             o_carry;
  logic [OUT_W-1:0] o_beats;
  zc_state_t        dbg_state;

  zero_count_accum #(
    .LEN   (LEN),
    .OUT_W (OUT_W)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_last  (i_last),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_zeros (o_zeros),
    .o_carry (o_carry),
    .o_beats (o_beats),
    .o_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int unsigned  mdl_total = 0;
  int unsigned  mdl_beats = 0;
  int           rdy_mode  = 0;   // 0: always ready, 1: random, 2: held low
  bit           hold_v    = 0;
  logic [W-1:0] hold_word;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int zeros_of(input logic [LEN-1:0] v);
    int n = 0;
    for (int i = 0; i < LEN; i++) if (v[i] == 1'b0) n++;
    return n;
  endfunction

  // Reference: true frame total in plain integers, then mapped to the output range.
  function automatic logic [W-1:0] frame_result(input int unsigned total, input int unsigned beats);
    int unsigned max_v = (1 << OUT_W) - 1;
    logic carry;
    logic [OUT_W-1:0] z;
    logic [OUT_W-1:0] b;
    carry = (total > max_v);
`ifdef ZERO_CNT_SAT_EN
    z = carry ? OUT_W'(max_v) : OUT_W'(total);
`else
    z = OUT_W'(total % (max_v + 1));
`endif
    b = OUT_W'(beats % (max_v + 1));
    return {carry, z, b};
  endfunction

  task automatic model_beat(input logic [LEN-1:0] a, input logic [LEN-1:0] b, input logic last);
    mdl_total += zeros_of(a) + zeros_of(b);
    mdl_beats++;
    if (last) begin
      exp_q.push_back(frame_result(mdl_total, mdl_beats));
      mdl_total = 0;
      mdl_beats = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [LEN-1:0] a, input logic [LEN-1:0] b, input logic last);
    bit rdy;
    int guard;
    guard   = 0;
    i_valid = 1'b1;
    i_a     = a;
    i_b     = b;
    i_last  = last;
    do begin
      @(negedge i_clk);
      rdy = o_ready;
      @(posedge i_clk);
      #1;
      guard++;
    end while (!rdy && guard < 100);
    i_valid = 1'b0;
    i_a     = LEN'($urandom);
    i_b     = LEN'($urandom);
    i_last  = 1'($urandom);
    if (!rdy) begin
      check("beat_accept_timeout", 32'(rdy), 32'd1);
    end else begin
      model_beat(a, b, last);
      if (last) begin
        @(negedge i_clk);
        check("latency_valid", 32'(o_valid), 32'd1);
      end
    end
  endtask

  // ---------------- downstream ready ----------------
  always @(posedge i_clk) begin
    #1;
    case (rdy_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = 1'($urandom_range(0, 1));
      default: i_ready = 1'b0;
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    got = {o_carry, o_zeros, o_beats};
    if (i_rst) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 32'(o_valid), 32'd1);
        check("hold_result", 32'(got), 32'(hold_word));
      end
      if (o_valid) check("ready_low_in_done", 32'(o_ready), 32'd0);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(got), 32'h1ff);
        end else begin
          exp = exp_q.pop_front();
          check("result", 32'(got), 32'(exp));
        end
        hold_v = 0;
      end else if (o_valid) begin
        hold_v    = 1;
        hold_word = got;
      end else begin
        hold_v = 0;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_a     = '0;
    i_b     = '0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    check("reset_ready_low", 32'(o_ready), 32'd0);
    idle(2);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("post_reset_ready", 32'(o_ready), 32'd1);
    check("post_reset_valid", 32'(o_valid), 32'd0);
    idle(1);

    // Mid-frame reset discards the partial frame.
    send_beat(4'b0000, 4'b0000, 1'b0);
    send_beat(4'b1111, 4'b0000, 1'b0);
    i_rst     = 1'b1;
    mdl_total = 0;
    mdl_beats = 0;
    @(negedge i_clk);
    check("rst_ready_low_1", 32'(o_ready), 32'd0);
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    check("rst_ready_low_2", 32'(o_ready), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_zeros", 32'(o_zeros), 32'd0);
    check("rst_carry", 32'(o_carry), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_release_ready", 32'(o_ready), 32'd1);
    idle(1);

    // Single-beat frame.
    send_beat(4'b0000, 4'b1111, 1'b1);
    idle(2);
    // Three-beat frame: 4 + 0 + 6.
    send_beat(4'b0101, 4'b0011, 1'b0);
    send_beat(4'b1111, 4'b1111, 1'b0);
    send_beat(4'b1000, 4'b0001, 1'b1);
    idle(2);
    // Overflow: 8 + 8 in a 4-bit accumulator.
    send_beat(4'b0000, 4'b0000, 1'b0);
    send_beat(4'b0000, 4'b0000, 1'b1);
    idle(2);

    // Backpressure: result held 5 cycles while a beat is offered.
    rdy_mode = 2;
    idle(1);
    send_beat(4'b0011, 4'b0000, 1'b1);
    i_valid = 1'b1;
    i_a     = 4'b0000;
    i_b     = 4'b0000;
    i_last  = 1'b1;
    repeat (5) begin
      @(posedge i_clk);
      #1;
      @(negedge i_clk);
      check("bp_ready", 32'(o_ready), 32'd0);
      check("bp_valid", 32'(o_valid), 32'd1);
    end
    i_valid  = 1'b0;
    rdy_mode = 0;
    idle(3);

    // Gapped frame with random data.
    for (int i = 0; i < 5; i++) begin
      send_beat(LEN'($urandom), LEN'($urandom), 1'(i == 4));
      if (i != 4) idle(1);
    end
    idle(1);

    // Back-to-back short frames, always ready.
    for (int f = 0; f < 6; f++) begin
      send_beat(LEN'($urandom), LEN'($urandom), 1'(f % 2));
    end
    idle(2);

    // Random frames, random gaps, random backpressure.
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      int nb;
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) begin
        send_beat(LEN'($urandom_range(0, 15)), LEN'($urandom_range(0, 15)), 1'(i == nb - 1));
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
    end

    // Drain outstanding results.
    rdy_mode = 0;
    guard    = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      idle(1);
      guard++;
    end
    idle(2);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
